// File: rtl/sh7604_divu.sv
// SH7604 division unit: signed 32/32 and 64/32 divide with overflow interrupt.
// Restoring divider, one quotient bit per CE cycle, fixed start-to-result latency.
module sh7604_divu #(
  parameter int DIV_LAT = 39
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [5:0]  IBUS_A,
  input  logic [31:0] IBUS_DI,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic [31:0] IBUS_DO,
  output logic        IBUS_BUSY,
  output logic        IRQ,
  output logic [7:0]  VEC
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ITER, S_FIXUP, S_PAD, S_DONE
  } state_t;

  localparam int LW = $clog2(DIV_LAT + 1);

  logic [31:0] dvsr, dvdnth, dvdntl;
  logic [1:0]  dvcr;
  logic [15:0] vcrdiv;

  state_t      state;
  logic [LW-1:0] lat;
  logic [4:0]  iter;
  logic [63:0] acc;
  logic [31:0] dmag, qres, rres;
  logic        qneg, rneg, ovf_op;

  logic        take, wr_ok, start;
  logic [2:0]  sel;
  logic [31:0] rdata;
  logic [63:0] dvd, dvd_mag;
  logic [31:0] dvs_mag;
  logic [32:0] top, diff;
  logic        ge, post_ovf;
  logic        unused_a;

  assign IBUS_BUSY = (state != S_IDLE);
  assign IRQ       = dvcr[0] & dvcr[1];
  assign VEC       = vcrdiv[7:0];
  assign unused_a  = ^{IBUS_A[5], IBUS_A[1:0]};

  assign sel   = IBUS_A[4:2];
  assign take  = IBUS_REQ & CE & ~IBUS_BUSY;
  assign wr_ok = take & IBUS_WE & (IBUS_BA == 4'hF);
  assign start = wr_ok & ((sel == 3'd1) | (sel == 3'd5) | (sel == 3'd7));

  assign dvd     = {dvdnth, dvdntl};
  assign dvd_mag = dvd[63] ? -dvd : dvd;
  assign dvs_mag = dvsr[31] ? -dvsr : dvsr;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign top  = acc[63:31];
  assign diff = top - {1'b0, dmag};
  assign ge   = ~diff[32];

  assign post_ovf = qneg ? (acc[31:0] > 32'h8000_0000) : acc[31];

  always_comb begin
    rdata = 32'h0;
    unique case (sel)
      3'd0: rdata = dvsr;
      3'd1: rdata = dvdntl;
      3'd2: rdata = {30'h0, dvcr};
      3'd3: rdata = {16'h0, vcrdiv};
      3'd4: rdata = dvdnth;
      3'd5: rdata = dvdntl;
      3'd6: rdata = dvdnth;
      3'd7: rdata = dvdntl;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dvsr    <= '0;
      dvdnth  <= '0;
      dvdntl  <= '0;
      dvcr    <= '0;
      vcrdiv  <= '0;
      IBUS_DO <= '0;
      state   <= S_IDLE;
      lat     <= '0;
      iter    <= '0;
      acc     <= '0;
      dmag    <= '0;
      qres    <= '0;
      rres    <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      ovf_op  <= 1'b0;
    end else if (CE) begin
      if (take && !IBUS_WE)
        IBUS_DO <= rdata;
      if (wr_ok) begin
        unique case (sel)
          3'd0: dvsr <= IBUS_DI;
          3'd1: begin
            dvdntl <= IBUS_DI;
            dvdnth <= {32{IBUS_DI[31]}};
          end
          3'd2: dvcr   <= IBUS_DI[1:0];
          3'd3: vcrdiv <= IBUS_DI[15:0];
          3'd4, 3'd6: dvdnth <= IBUS_DI;
          3'd5, 3'd7: dvdntl <= IBUS_DI;
        endcase
      end
      if (state != S_IDLE)
        lat <= lat + LW'(1);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SETUP;
            lat   <= LW'(1);
          end
        end
        S_SETUP: begin
          acc    <= dvd_mag;
          dmag   <= dvs_mag;
          qneg   <= dvdnth[31] ^ dvsr[31];
          rneg   <= dvdnth[31];
          ovf_op <= (dvsr == 32'h0) | (dvd_mag[63:32] >= dvs_mag);
          iter   <= '0;
          state  <= S_ITER;
        end
        S_ITER: begin
          acc  <= {ge ? diff[31:0] : top[31:0], acc[30:0], ge};
          iter <= iter + 5'd1;
          if (iter == 5'd31)
            state <= S_FIXUP;
        end
        S_FIXUP: begin
          ovf_op <= ovf_op | post_ovf;
          qres   <= qneg ? -acc[31:0] : acc[31:0];
          rres   <= rneg ? -acc[63:32] : acc[63:32];
          state  <= S_PAD;
        end
        S_PAD: begin
          if (lat >= LW'(DIV_LAT - 1))
            state <= S_DONE;
        end
        S_DONE: begin
          if (ovf_op) begin
            dvcr[0] <= 1'b1;
            if (!dvcr[1])
              dvdntl <= qneg ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end else begin
            dvdntl <= qres;
            dvdnth <= rres;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sh7604_divu.sv
// Bench for sh7604_divu: directed cases plus random divides against an
// arithmetic reference model, reads checked through a scoreboard queue.
module tb_sh7604_divu;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE = 1'b0;
  logic [5:0]  IBUS_A = '0;
  logic [31:0] IBUS_DI = '0;
  logic [3:0]  IBUS_BA = '0;
  logic        IBUS_WE = 1'b0;
  logic        IBUS_REQ = 1'b0;
  logic [31:0] IBUS_DO;
  logic        IBUS_BUSY;
  logic        IRQ;
  logic [7:0]  VEC;

  sh7604_divu dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
    .IBUS_DO(IBUS_DO), .IBUS_BUSY(IBUS_BUSY),
    .IRQ(IRQ), .VEC(VEC)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_dvsr, m_h, m_l;
  logic        m_ovfie, m_ovf;
  logic [15:0] m_vcr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mreset();
    m_dvsr = 0; m_h = 0; m_l = 0;
    m_ovfie = 0; m_ovf = 0; m_vcr = 0;
  endtask

  // Reference: signed divide by plain 64-bit arithmetic
  task automatic mdiv();
    logic [63:0] n, an, q, r;
    logic [31:0] ad;
    logic        sn, sd, neg, ov;
    n  = {m_h, m_l};
    sn = n[63];
    sd = m_dvsr[31];
    an = sn ? (64'h0 - n) : n;
    ad = sd ? (32'h0 - m_dvsr) : m_dvsr;
    neg = sn ^ sd;
    q = 0; r = 0;
    if (ad == 0) ov = 1;
    else begin
      q  = an / {32'h0, ad};
      r  = an % {32'h0, ad};
      ov = q > (neg ? 64'h8000_0000 : 64'h7FFF_FFFF);
    end
    if (ov) begin
      m_ovf = 1;
      if (!m_ovfie) m_l = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      m_l = neg ? (32'h0 - q[31:0]) : q[31:0];
      m_h = sn ? (32'h0 - r[31:0]) : r[31:0];
    end
  endtask

  task automatic mwrite(input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] ba);
    if (ba == 4'hF) begin
      case (a[4:2])
        3'd0: m_dvsr = d;
        3'd1: begin m_l = d; m_h = {32{d[31]}}; mdiv(); end
        3'd2: begin m_ovfie = d[1]; m_ovf = d[0]; end
        3'd3: m_vcr = d[15:0];
        3'd4, 3'd6: m_h = d;
        default: begin m_l = d; mdiv(); end
      endcase
    end
  endtask

  function automatic logic [31:0] mread(input logic [5:0] a);
    case (a[4:2])
      3'd0: return m_dvsr;
      3'd2: return {30'h0, m_ovfie, m_ovf};
      3'd3: return {16'h0, m_vcr};
      3'd4, 3'd6: return m_h;
      default: return m_l;
    endcase
  endfunction

  task automatic access(input logic we, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] ba,
                        output int nb);
    IBUS_REQ = 1; IBUS_WE = we; IBUS_A = a; IBUS_DI = d; IBUS_BA = ba;
    nb = 0;
    @(negedge CLK);
    while (IBUS_BUSY && nb < 200) begin
      nb++;
      @(negedge CLK);
    end
    if (nb >= 200) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got busy %0d cycles required < 200", nb);
    end
    @(posedge CLK);
    #1;
    IBUS_REQ = 0; IBUS_WE = 0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d,
                    input logic [3:0] ba = 4'hF);
    int nb;
    access(1'b1, a, d, ba, nb);
    mwrite(a, d, ba);
  endtask

  task automatic rd(input logic [5:0] a, output int nb);
    exp_q.push_back(mread(a));
    access(1'b0, a, 32'h0, 4'hF, nb);
  endtask

  task automatic rd3();
    int nb;
    rd(6'h14, nb);
    rd(6'h10, nb);
    rd(6'h08, nb);
  endtask

  // Monitor: every read taken by the DUT is compared against the queue
  initial begin
    forever begin
      @(posedge CLK);
      if (RST_N && IBUS_REQ && CE && !IBUS_BUSY && !IBUS_WE) begin
        #2;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got %h required no read", IBUS_DO);
        end else
          chk("rd_data", IBUS_DO, exp_q.pop_front());
      end
    end
  end

  initial begin
    int nb;
    logic [31:0] d, s, h;
    mreset();
    CE = 1;
    RST_N = 0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    chk("rst_do", IBUS_DO, 0);
    chk("rst_busy", {31'h0, IBUS_BUSY}, 0);
    chk("rst_irq", {31'h0, IRQ}, 0);
    rd(6'h00, nb); rd3();

    // -100 / 7
    wr(6'h00, 7);
    wr(6'h04, 32'hFFFF_FF9C);
    rd(6'h14, nb);
    chk("lat_immediate", nb, 39);
    rd(6'h10, nb); rd(6'h08, nb);

    // 2^32 / 16
    wr(6'h10, 1); wr(6'h00, 32'h10); wr(6'h14, 0);
    rd3();

    // divide by zero, OVFIE=0
    wr(6'h00, 0); wr(6'h08, 0); wr(6'h04, 5);
    rd3();
    chk("dz_irq", {31'h0, IRQ}, 0);

    // overflow with OVFIE=1: registers kept, interrupt raised
    wr(6'h08, 32'hFFFF_FFFE);
    rd(6'h08, nb);
    wr(6'h0C, 32'hABCD_0055);
    rd(6'h0C, nb);
    wr(6'h10, 32'h10); wr(6'h00, 2); wr(6'h14, 0);
    rd3();
    chk("ovf_irq", {31'h0, IRQ}, 1);
    chk("vec", {24'h0, VEC}, 32'h55);
    wr(6'h08, 2);
    chk("irq_clear", {31'h0, IRQ}, 0);

    // 0x80000000 / -1
    wr(6'h08, 0); wr(6'h00, 32'hFFFF_FFFF); wr(6'h04, 32'h8000_0000);
    rd3();

    // read issued one CE after start
    wr(6'h00, 3); wr(6'h04, 100);
    @(posedge CLK); #1;
    rd(6'h14, nb);
    chk("lat_busy38", nb, 38);

    // CE low freezes the operation
    wr(6'h04, 32'hFFFF_FFCE);
    CE = 0;
    repeat (20) @(posedge CLK);
    #1;
    chk("ce_hold_busy", {31'h0, IBUS_BUSY}, 1);
    CE = 1;
    rd(6'h14, nb);
    chk("ce_freeze_lat", nb, 39);
    rd(6'h10, nb);

    // partial byte enables are ignored
    wr(6'h00, 32'h1234, 4'h3);
    rd(6'h00, nb);
    wr(6'h04, 77, 4'h3);
    rd(6'h14, nb);
    chk("ba_nostart", nb, 0);
    rd(6'h38, nb); rd(6'h3C, nb);

    // reset in the middle of the iterations
    wr(6'h00, 9); wr(6'h04, 1000);
    repeat (10) @(posedge CLK);
    #1 RST_N = 0;
    @(posedge CLK);
    #1 RST_N = 1;
    mreset();
    chk("midrst_busy", {31'h0, IBUS_BUSY}, 0);
    chk("midrst_do", IBUS_DO, 0);
    rd(6'h00, nb); rd3();
    wr(6'h00, 9); wr(6'h04, 1000);
    rd3();

    // random operations
    for (int i = 0; i < 30; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) s = 32'h0 - s;
      wr(6'h08, {30'h0, 1'($urandom_range(0, 1)), 1'b0});
      wr(6'h00, s);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wr(6'h04, d);
      end else begin
        h = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) h = 32'h0 - h;
        wr(6'h10, h);
        d = $urandom;
        wr(6'h14, d);
      end
      rd3();
      chk("rnd_irq", {31'h0, IRQ}, {31'h0, m_ovf & m_ovfie});
    end

    repeat (5) @(posedge CLK);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sh7604_divu.md
Name: sh7604_divu

Overview:
- SH7604 on-chip division unit. Performs signed 32/32 and 64/32 division.
- Sits on the internal peripheral bus and implements the DIVU registers DVSR, DVDNT, DVCR, VCRDIV, DVDNTH and DVDNTL, with their masks and init values.
- Raises the overflow interrupt request to the INTC. The INTC applies IPRA.DIVUIP as the priority level.

Parameters:
- DIV_LAT, 39, number of CE cycles from the start write to the result being valid.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous reset, active-low; one clock
- CE  in  1  clock enable; all state advances only when CE=1
- IBUS_A  in  6  register offset from FFFFFF00 (bit5 is ignored: 20–3F mirrors 00–1F)
- IBUS_DI  in  32  write data
- IBUS_BA  in  4  byte enables
- IBUS_WE  in  1  write strobe
- IBUS_REQ  in  1  access request, DIVU area selected
- IBUS_DO  out  32  read data
- IBUS_BUSY  out  1  wait; the bus holds the access while this is 1
- IRQ  out  1  overflow interrupt request
- VEC  out  8  interrupt vector, equal to VCRDIV[7:0]

Behaviour:
- Register map, by offset: 00 DVSR, 04 DVDNT, 08 DVCR, 0C VCRDIV, 10 DVDNTH, 14 DVDNTL. Offsets 18/1C read as DVDNTH/DVDNTL.
- Reads are masked: DVCR returns bits 1:0 only; VCRDIV returns bits 15:0 only.
- An access is taken when IBUS_REQ=1, CE=1 and IBUS_BUSY=0.
- A write is accepted only if IBUS_BA=4'hF; any other BA makes the write a no-op. Reads ignore BA.
- Write to DVDNT:
  - DVDNTL <= data, DVDNTH <= sign-extension of data.
  - Starts a 32/32 operation.
- Write to DVDNTL:
  - DVDNTL <= data.
  - Starts a 64/32 operation using {DVDNTH, data}.
- Writes to DVSR, DVDNTH and VCRDIV only store the value.
- Write to DVCR: stores bits 1:0 (OVFIE, OVF). OVF can be cleared or set by software.
- State machine:
  - IDLE -> (start write) -> SETUP -> ITER (32 CE cycles) -> FIXUP -> PAD until DIV_LAT CE cycles have elapsed since the write -> DONE -> IDLE.
  - Result registers are written on the DONE cycle.
  - Any register access during a non-IDLE state holds IBUS_BUSY=1 until the state returns to IDLE. The access then completes; reads see the new result.
- Arithmetic:
  - Compute |dividend| (64b) and |divisor| (32b).
  - Quotient sign = dividend sign XOR divisor sign. Remainder sign = dividend sign.
  - Restoring division, one quotient bit per ITER cycle.
  - Pre-check in SETUP: if |dividend|[63:32] >= |divisor|, or divisor = 0, the operation is an overflow. For divide-by-zero the divisor is treated as positive.
  - Post-check in FIXUP: magnitude Q > 2^31-1 with a positive sign, or Q > 2^31 with a negative sign, is an overflow.
- No overflow: DVDNTL = DVDNT = signed quotient; DVDNTH = signed remainder.
- Overflow: DVCR.OVF <= 1 in DONE.
  - If OVFIE=0: DVDNTL = DVDNT = 32'h7FFFFFFF for a positive sign, 32'h80000000 for a negative sign. DVDNTH is unchanged.
  - If OVFIE=1: DVDNTH and DVDNTL are unchanged.
- IRQ = DVCR.OVF & DVCR.OVFIE, combinational from the registers. It clears when software writes OVF=0 or OVFIE=0.
- DVDNT and DVDNTL are one register; a read of either returns the same value.
- Reset values: DVSR, DVDNT/DVDNTL, DVDNTH = 0; DVCR = 0; VCRDIV = 0; IBUS_DO = 0; IBUS_BUSY = 0; IRQ = 0; state IDLE.
- Reset mid-operation aborts the division with no register update.
- CE=0 freezes all state, including the latency count. Outputs are held.

Test Plan:
- DVSR=7, write DVDNT=32'hFFFFFF9C (-100) -> after 39 CE: DVDNTL=32'hFFFFFFF2 (-14), DVDNTH=32'hFFFFFFFE (-2), OVF=0.
- DVDNTH=1, DVSR=16#10, write DVDNTL=0 -> DVDNTL=32'h10000000, DVDNTH=0.
- DVSR=0, OVFIE=0, write DVDNT=5 -> OVF=1, DVDNTL=32'h7FFFFFFF, DVDNTH=0, IRQ=0.
- OVFIE=1, VCRDIV=16'h0055, DVDNTH=16#10, DVSR=2, write DVDNTL=0 -> registers unchanged, IRQ=1, VEC=8'h55; write DVCR=2 (OVFIE=1, OVF=0) -> IRQ=0.
- DVSR=32'hFFFFFFFF, write DVDNT=32'h80000000 -> overflow: DVDNTL=32'h7FFFFFFF.
- Read DVDNTL 1 CE after the start -> IBUS_BUSY=1 for 38 CE cycles, then returns the quotient.
- Assert RST_N=0 at ITER cycle 10 -> all registers 0, BUSY=0, and the next op behaves normally.
- Write with BA=4'h3 -> no effect.
